// File: rtl/mux_pipe_pkg.sv
// Shared helpers for the registered N-way selector: select-width function and input-count limit.
package mux_pipe_pkg;

  localparam int MAX_NUM_IN = 16;

  // A 1-input-wide select still needs one bit so port widths never collapse to zero.
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_skid_slot.sv
// One-entry holding register with a full flag. It parks a beat while the output stage is stalled.
module mux_skid_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         full
);

  // NOTE: the data word is reset as well as the flag, so nothing undefined can ever be forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      full <= 1'b0;
    end else if (load) begin
      q    <= d;
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_nway_pipe.sv
// N-input WIDTH-bit selector with a registered valid/ready output stage.
// Define MUX_NWAY_PIPE_SKID_EN to add a one-entry skid slot that registers in_ready.
module mux_nway_pipe
  import mux_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  beat_t sel_beat;
  beat_t out_beat;
  logic  in_fire;
  logic  out_free;

  // NOTE: every field gets a default before the loop, so no path leaves a latch behind.
  always_comb begin
    sel_beat.data = '0;
    sel_beat.sel  = in_sel;
    sel_beat.err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_beat.data = in_data[k*WIDTH +: WIDTH];
        sel_beat.err  = 1'b0;
      end
    end
  end

  assign in_fire  = in_valid & in_ready;
  assign out_free = !out_valid | out_ready;

`ifdef MUX_NWAY_PIPE_SKID_EN
  logic [BEAT_W-1:0] skid_q;
  logic              skid_full;
  logic              skid_load;
  logic              skid_unload;

  // A beat accepted while the output is stalled waits in the slot; the slot is older, so it drains first.
  assign skid_load   = in_fire & !out_free;
  assign skid_unload = out_free & skid_full;
  assign in_ready    = !skid_full;

  mux_skid_slot #(.W(BEAT_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .unload (skid_unload),
    .d      (sel_beat),
    .q      (skid_q),
    .full   (skid_full)
  );

  // NOTE: non-blocking assignments so all state updates see the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_beat  <= '0;
      out_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_full) begin
        out_beat  <= beat_t'(skid_q);
        out_valid <= 1'b1;
      end else if (in_fire) begin
        out_beat  <= sel_beat;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  assign in_ready = out_free;

  // NOTE: non-blocking assignments so all state updates see the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_beat  <= '0;
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_beat  <= sel_beat;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  assign out_data = out_beat.data;
  assign out_sel  = out_beat.sel;
  assign out_err  = out_beat.err;

endmodule

// File: tb/tb_mux_nway_pipe.sv
// Bench for mux_nway_pipe: 4-input and 3-input instances share stimulus; a queue model checks every cycle.
module tb_mux_nway_pipe;

`ifdef MUX_NWAY_PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready4, out_valid4, out_err4;
  logic [31:0]  out_data4;
  logic [1:0]   out_sel4;
  logic         in_ready3, out_valid3, out_err3;
  logic [31:0]  out_data3;
  logic [1:0]   out_sel3;

  always #5 clk = ~clk;

  mux_nway_pipe #(.WIDTH(32), .NUM_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_sel(out_sel4), .out_err(out_err4),
    .out_valid(out_valid4), .out_ready(out_ready)
  );

  mux_nway_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready3), .out_data(out_data3), .out_sel(out_sel3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        err;
  } exp_t;

  // Expected beat from the selection rule: in-range index picks a word, otherwise zero with err.
  function automatic exp_t model(input logic [1:0] sel, input logic [127:0] din, input int n);
    exp_t e;
    e.sel = sel;
    if (int'(sel) < n) begin
      e.data = din[int'(sel)*32 +: 32];
      e.err  = 1'b0;
    end else begin
      e.data = '0;
      e.err  = 1'b1;
    end
    return e;
  endfunction

  exp_t q4[$];
  exp_t q3[$];

  // Beats in flight form a FIFO of capacity CAP; out_valid means the FIFO is non-empty.
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
      q3.delete();
      check("rst_out_valid4", out_valid4, 0);
      check("rst_out_valid3", out_valid3, 0);
      check("rst_out_data4", out_data4, 0);
    end else begin
      int  pend;
      bit  exp_ready;
      pend      = q4.size();
      exp_ready = (CAP == 2) ? (pend < 2) : (pend == 0 || out_ready);
      check("in_ready4", in_ready4, exp_ready);
      check("in_ready3", in_ready3, exp_ready);
      check("out_valid4", out_valid4, pend > 0);
      check("out_valid3", out_valid3, pend > 0);
      if (pend > 0) begin
        check("sb_data4", out_data4, q4[0].data);
        check("sb_sel4", out_sel4, q4[0].sel);
        check("sb_err4", out_err4, q4[0].err);
        check("sb_data3", out_data3, q3[0].data);
        check("sb_sel3", out_sel3, q3[0].sel);
        check("sb_err3", out_err3, q3[0].err);
        if (out_ready) begin
          void'(q4.pop_front());
          void'(q3.pop_front());
        end
      end
      if (in_valid && exp_ready) begin
        q4.push_back(model(in_sel, in_data, 4));
        q3.push_back(model(in_sel, in_data, 3));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    int          held_cnt;

    rst_n     = 1'b1;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("reset_valid", out_valid4, 0);
    check("reset_data", out_data4, 0);
    check("reset_sel", out_sel4, 0);
    check("reset_err", out_err4, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Basic select and a back-to-back stream, one beat per cycle.
    in_data   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_valid  = 1'b1;
    in_sel    = 2'd2;
    out_ready = 1'b1;
    step();
    check("sel2_data", out_data4, 32'h33333333);
    check("sel2_sel", out_sel4, 2);
    check("sel2_err", out_err4, 0);
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k);
      step();
      check("stream_valid", out_valid4, 1);
      check("stream_sel", out_sel4, 64'(k));
      check("stream_data", out_data4, 64'((k + 1) * 32'h11111111));
    end

    // Out-of-range index on the 3-input instance.
    in_sel = 2'd3;
    step();
    check("oor_data3", out_data3, 0);
    check("oor_err3", out_err3, 1);
    check("oor_sel3", out_sel3, 3);
    check("inr_data4", out_data4, 32'h44444444);
    in_sel = 2'd0;
    step();
    check("after_oor_err3", out_err3, 0);
    check("after_oor_data3", out_data3, 32'h11111111);
    in_valid = 1'b0;
    step();

    // Backpressure for five cycles: held word stays put, then the held beats drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    step();
    held = out_data4;
    check("bp_first", held, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      step();
      check("bp_stable", out_data4, held);
      check("bp_valid", out_valid4, 1);
    end
    check("bp_in_ready", in_ready4, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    held_cnt  = 0;
    repeat (4) begin
      if (out_valid4) held_cnt++;
      step();
    end
    check("bp_held_cnt", held_cnt, CAP);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_sel    = 2'($urandom);
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      step();
    end
    for (int c = 0; c < 200; c++) begin
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      in_sel    = 2'($urandom);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
    end

    // Reset mid-stream with a valid beat on the output.
    check("mid_valid", out_valid4, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid4, 0);
    check("mid_rst_data", out_data4, 0);
    step();
    rst_n = 1'b1;
    step();

    // Fill every holding stage, then reset: nothing stale may emerge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("full_rst_valid", out_valid4, 0);
    check("full_rst_data", out_data4, 0);
    step();
    step();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("post_rst_ready", in_ready4, 1);
    check("post_rst_valid", out_valid4, 0);
    out_ready = 1'b1;
    repeat (3) step();
    check("no_stale_valid", out_valid4, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
